// File: rtl/pipe_pkg.sv
// Shared definitions for the instruction fetch pipeline: the fetch state
// encoding, the default boot address and the basic instruction constants.
package pipe_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_VALID = 2'd2
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] NOP              = 32'h0000_0000;
  localparam int unsigned PC_INC           = 4;

endpackage

// File: rtl/fetch_pc_gen.sv
// Next fetch address selection. A redirect seen on the consuming edge wins,
// then a previously stored (delay-slot deferred) target, then pc + 4 with
// natural wrap at 2^WIDTH.
module fetch_pc_gen
  import pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] pc,
  input  logic             pend_valid,
  input  logic [WIDTH-1:0] pend_pc,
  input  logic             redirect_now,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic [WIDTH-1:0] next_pc
);

  // Priority mux: live redirect, then pending target, then sequential.
  always_comb begin
    next_pc = pc + WIDTH'(PC_INC);
    if (redirect_now) begin
      next_pc = redirect_pc;
    end else if (pend_valid) begin
      next_pc = pend_pc;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues one instruction-memory read at a time,
// presents the returned word with its address, and stalls on data hazards or
// a busy mult/div unit. Redirects keep the delay slot: the instruction that is
// valid or in flight when a redirect is taken is still delivered, and the
// target is used for the fetch after it.
//
// Optional feature: define FETCH_ADEL_CHECK_EN to trap misaligned fetch
// addresses (no read, adel_out raised with the bad pc). Without it adel_out is
// tied low and the two low address bits are forced to zero.
module fetch_stage
  import pipe_pkg::*;
#(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEFAULT)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall_data,
  input  logic [2:0]       busy,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_rvalid,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic [WIDTH-1:0] instr_out,
  output logic [WIDTH-1:0] pc_out,
  output logic             instr_valid,
  output logic             adel_out
);

  fetch_state_e     state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] instr_q, instr_d;
  logic [WIDTH-1:0] pc_out_q, pc_out_d;
  logic             valid_q, valid_d;
  logic             req_q, req_d;
  logic             pend_valid_q, pend_valid_d;
  logic [WIDTH-1:0] pend_pc_q, pend_pc_d;
`ifdef FETCH_ADEL_CHECK_EN
  logic             adel_q, adel_d;
`endif

  logic             hold;
  logic             consume;
  logic             redirect_now;
  logic [WIDTH-1:0] next_pc;

  assign hold         = stall_data | (|busy);
  assign consume      = (state_q == S_VALID) && !hold;
  assign redirect_now = redirect_valid && !hold;

  fetch_pc_gen #(
    .WIDTH (WIDTH)
  ) u_pc_gen (
    .pc           (pc_q),
    .pend_valid   (pend_valid_q),
    .pend_pc      (pend_pc_q),
    .redirect_now (redirect_now),
    .redirect_pc  (redirect_pc),
    .next_pc      (next_pc)
  );

  // Next-state and output computation for the IDLE/WAIT/VALID fetch sequencer.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    pc_out_d     = pc_out_q;
    valid_d      = valid_q;
    req_d        = 1'b0;
    pend_valid_d = pend_valid_q;
    pend_pc_d    = pend_pc_q;
`ifdef FETCH_ADEL_CHECK_EN
    adel_d       = adel_q;
`endif

    // A redirect that is not consumed this edge is parked; a newer one
    // overwrites an older one that has not yet been used.
    if (redirect_now && !consume) begin
      pend_valid_d = 1'b1;
      pend_pc_d    = redirect_pc;
    end

    case (state_q)
      S_IDLE: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          instr_d  = imem_rdata;
          pc_out_d = pc_q;
          valid_d  = 1'b1;
          state_d  = S_VALID;
        end
      end
      S_VALID: begin
        if (consume) begin
          pc_d         = next_pc;
          pend_valid_d = 1'b0;
          valid_d      = 1'b0;
          instr_d      = WIDTH'(NOP);
`ifdef FETCH_ADEL_CHECK_EN
          adel_d       = 1'b0;
          if (next_pc[1:0] != 2'b00) begin
            valid_d  = 1'b1;
            pc_out_d = next_pc;
            adel_d   = 1'b1;
            state_d  = S_VALID;
          end else begin
            req_d   = 1'b1;
            state_d = S_WAIT;
          end
`else
          req_d        = 1'b1;
          state_d      = S_WAIT;
`endif
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered outputs, all forced to boot values on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      instr_q      <= WIDTH'(NOP);
      pc_out_q     <= RESET_PC;
      valid_q      <= 1'b0;
      req_q        <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_pc_q    <= '0;
`ifdef FETCH_ADEL_CHECK_EN
      adel_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      pc_out_q     <= pc_out_d;
      valid_q      <= valid_d;
      req_q        <= req_d;
      pend_valid_q <= pend_valid_d;
      pend_pc_q    <= pend_pc_d;
`ifdef FETCH_ADEL_CHECK_EN
      adel_q       <= adel_d;
`endif
    end
  end

  // The first read after reset is requested straight from IDLE so it goes out
  // in the first cycle after release; later reads use the registered pulse.
  assign imem_req    = req_q | ((state_q == S_IDLE) & reset);
  assign instr_out   = instr_q;
  assign pc_out      = pc_out_q;
  assign instr_valid = valid_q;

`ifdef FETCH_ADEL_CHECK_EN
  assign imem_addr = pc_q;
  assign adel_out  = adel_q;
`else
  assign imem_addr = {pc_q[WIDTH-1:2], 2'b00};
  assign adel_out  = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage with a simple fixed-latency instruction
// memory. Scenarios run back to back; each task drives its stimulus on falling
// edges and compares outputs against hand-computed values.
// Build with FETCH_ADEL_CHECK_EN defined to exercise the misaligned-fetch trap.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_data;
  logic [2:0]  busy;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        instr_valid;
  logic        adel_out;

  int checks = 0;
  int errors = 0;

  int          mem_lat   = 1;
  int          mem_cnt   = 0;
  int          req_count = 0;
  logic [31:0] mem_addr  = '0;

  fetch_stage dut (
    .clk            (clk),
    .reset          (reset),
    .stall_data     (stall_data),
    .busy           (busy),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .instr_out      (instr_out),
    .pc_out         (pc_out),
    .instr_valid    (instr_valid),
    .adel_out       (adel_out)
  );

  always #5 clk = ~clk;

  // Instruction memory contents: the boot word at 0x3000, a tagged address elsewhere.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_3000) return 32'h2402_0001;
    return 32'hA500_0000 | a;
  endfunction

  // Memory responder: latches a request at the rising edge and returns rvalid
  // mem_lat cycles later; it knows nothing about the DUT reset.
  always @(posedge clk) begin
    logic        req_seen;
    logic [31:0] addr_seen;
    req_seen  = imem_req;
    addr_seen = imem_addr;
    #1;
    imem_rvalid = 1'b0;
    if (req_seen) begin
      req_count = req_count + 1;
      mem_addr  = addr_seen;
      mem_cnt   = mem_lat;
    end
    if (mem_cnt > 0) begin
      mem_cnt = mem_cnt - 1;
      if (mem_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(mem_addr);
      end
    end
  end

  // Hard stop in case the sequence ever loses track of time.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic test_reset();
    reset = 1'b0; stall_data = 1'b0; busy = 3'b000;
    redirect_valid = 1'b0; redirect_pc = '0;
    imem_rvalid = 1'b0; imem_rdata = '0;
    repeat (3) @(negedge clk);
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_valid got=%0b exp=0", instr_valid); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL rst_req got=%0b exp=0", imem_req); end
    checks++; if (instr_out !== 32'h0) begin errors++; $display("[TB] FAIL rst_instr got=%h exp=0", instr_out); end
    checks++; if (pc_out !== 32'h3000) begin errors++; $display("[TB] FAIL rst_pc_out got=%h exp=3000", pc_out); end
    checks++; if (adel_out !== 1'b0) begin errors++; $display("[TB] FAIL rst_adel got=%0b exp=0", adel_out); end
  endtask

  task automatic test_first_fetch();
    reset = 1'b1; #1;
    checks++; if (imem_req !== 1'b1) begin errors++; $display("[TB] FAIL first_req got=%0b exp=1", imem_req); end
    checks++; if (imem_addr !== 32'h3000) begin errors++; $display("[TB] FAIL first_addr got=%h exp=3000", imem_addr); end
    @(negedge clk);
    checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL first_req_pulse got=%0b exp=0", imem_req); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL first_wait_valid got=%0b exp=0", instr_valid); end
    @(negedge clk);
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("[TB] FAIL first_valid got=%0b exp=1", instr_valid); end
    checks++; if (instr_out !== 32'h2402_0001) begin errors++; $display("[TB] FAIL first_instr got=%h exp=24020001", instr_out); end
    checks++; if (pc_out !== 32'h3000) begin errors++; $display("[TB] FAIL first_pc_out got=%h exp=3000", pc_out); end
    stall_data = 1'b1;
  endtask

  task automatic test_stall();
    int base;
    base = req_count;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (instr_valid !== 1'b1) begin errors++; $display("[TB] FAIL stall_valid[%0d] got=%0b exp=1", i, instr_valid); end
      checks++; if (instr_out !== 32'h2402_0001) begin errors++; $display("[TB] FAIL stall_instr[%0d] got=%h exp=24020001", i, instr_out); end
      checks++; if (pc_out !== 32'h3000) begin errors++; $display("[TB] FAIL stall_pc_out[%0d] got=%h exp=3000", i, pc_out); end
      checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL stall_req[%0d] got=%0b exp=0", i, imem_req); end
    end
    checks++; if (req_count !== base) begin errors++; $display("[TB] FAIL stall_no_reads got=%0d exp=%0d", req_count, base); end
    stall_data = 1'b0;
    @(negedge clk);
    checks++; if (imem_req !== 1'b1) begin errors++; $display("[TB] FAIL stall_rel_req got=%0b exp=1", imem_req); end
    checks++; if (imem_addr !== 32'h3004) begin errors++; $display("[TB] FAIL stall_rel_addr got=%h exp=3004", imem_addr); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL stall_rel_valid got=%0b exp=0", instr_valid); end
    checks++; if (instr_out !== 32'h0) begin errors++; $display("[TB] FAIL stall_rel_nop got=%h exp=0", instr_out); end
  endtask

  task automatic test_busy();
    busy = 3'b010;
    @(negedge clk);
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL busy_wait_valid got=%0b exp=0", instr_valid); end
    @(negedge clk);
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("[TB] FAIL busy_capture got=%0b exp=1", instr_valid); end
    checks++; if (instr_out !== 32'hA500_3004) begin errors++; $display("[TB] FAIL busy_instr got=%h exp=a5003004", instr_out); end
    checks++; if (pc_out !== 32'h3004) begin errors++; $display("[TB] FAIL busy_pc_out got=%h exp=3004", pc_out); end
    @(negedge clk);
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("[TB] FAIL busy_hold_valid got=%0b exp=1", instr_valid); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL busy_hold_req got=%0b exp=0", imem_req); end
    busy = 3'b000;
    @(negedge clk);
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL busy_consumed got=%0b exp=0", instr_valid); end
    checks++; if (imem_req !== 1'b1) begin errors++; $display("[TB] FAIL busy_next_req got=%0b exp=1", imem_req); end
    checks++; if (imem_addr !== 32'h3008) begin errors++; $display("[TB] FAIL busy_next_addr got=%h exp=3008", imem_addr); end
  endtask

  task automatic test_redirect_delay_slot();
    redirect_valid = 1'b1; redirect_pc = 32'h3100;
    @(negedge clk);
    redirect_valid = 1'b0;
    @(negedge clk);
    checks++; if (pc_out !== 32'h3008) begin errors++; $display("[TB] FAIL slot_pc_out got=%h exp=3008", pc_out); end
    checks++; if (instr_out !== 32'hA500_3008) begin errors++; $display("[TB] FAIL slot_instr got=%h exp=a5003008", instr_out); end
    @(negedge clk);
    checks++; if (imem_addr !== 32'h3100) begin errors++; $display("[TB] FAIL redir_addr got=%h exp=3100", imem_addr); end
    checks++; if (imem_req !== 1'b1) begin errors++; $display("[TB] FAIL redir_req got=%0b exp=1", imem_req); end
    repeat (2) @(negedge clk);
    checks++; if (pc_out !== 32'h3100) begin errors++; $display("[TB] FAIL redir_pc_out got=%h exp=3100", pc_out); end
    checks++; if (instr_out !== 32'hA500_3100) begin errors++; $display("[TB] FAIL redir_instr got=%h exp=a5003100", instr_out); end
    @(negedge clk);
    checks++; if (imem_addr !== 32'h3104) begin errors++; $display("[TB] FAIL redir_seq_addr got=%h exp=3104", imem_addr); end
  endtask

  task automatic test_redirect_hold();
    stall_data = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (pc_out !== 32'h3104) begin errors++; $display("[TB] FAIL rhold_pc_out got=%h exp=3104", pc_out); end
    redirect_valid = 1'b1; redirect_pc = 32'h4000;
    @(negedge clk);
    redirect_valid = 1'b0; stall_data = 1'b0;
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("[TB] FAIL rhold_valid got=%0b exp=1", instr_valid); end
    @(negedge clk);
    checks++; if (imem_addr !== 32'h3108) begin errors++; $display("[TB] FAIL rhold_ignored got=%h exp=3108", imem_addr); end
  endtask

  task automatic test_redirect_coincident();
    repeat (2) @(negedge clk);
    checks++; if (pc_out !== 32'h3108) begin errors++; $display("[TB] FAIL coin_pc_out got=%h exp=3108", pc_out); end
    redirect_valid = 1'b1; redirect_pc = 32'h5000;
    @(negedge clk);
    checks++; if (imem_addr !== 32'h5000) begin errors++; $display("[TB] FAIL coin_addr got=%h exp=5000", imem_addr); end
    checks++; if (imem_req !== 1'b1) begin errors++; $display("[TB] FAIL coin_req got=%0b exp=1", imem_req); end
    redirect_pc = 32'h6000;
    @(negedge clk);
    redirect_pc = 32'h7000;
    @(negedge clk);
    redirect_valid = 1'b0;
    checks++; if (pc_out !== 32'h5000) begin errors++; $display("[TB] FAIL over_pc_out got=%h exp=5000", pc_out); end
    checks++; if (instr_out !== 32'hA500_5000) begin errors++; $display("[TB] FAIL over_instr got=%h exp=a5005000", instr_out); end
    @(negedge clk);
    checks++; if (imem_addr !== 32'h7000) begin errors++; $display("[TB] FAIL over_addr got=%h exp=7000", imem_addr); end
  endtask

  task automatic test_reset_mid_read();
    mem_lat = 3;
    @(negedge clk);
    reset = 1'b0; #1;
    mem_lat = 1;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_valid got=%0b exp=0", instr_valid); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_req got=%0b exp=0", imem_req); end
    checks++; if (pc_out !== 32'h3000) begin errors++; $display("[TB] FAIL mid_rst_pc_out got=%h exp=3000", pc_out); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_stale[%0d] got=%0b exp=0", i, instr_valid); end
    end
    reset = 1'b1; #1;
    checks++; if (imem_req !== 1'b1) begin errors++; $display("[TB] FAIL refetch_req got=%0b exp=1", imem_req); end
    checks++; if (imem_addr !== 32'h3000) begin errors++; $display("[TB] FAIL refetch_addr got=%h exp=3000", imem_addr); end
    repeat (2) @(negedge clk);
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("[TB] FAIL refetch_valid got=%0b exp=1", instr_valid); end
    checks++; if (instr_out !== 32'h2402_0001) begin errors++; $display("[TB] FAIL refetch_instr got=%h exp=24020001", instr_out); end
  endtask

  task automatic test_misaligned();
    int base;
    redirect_valid = 1'b1; redirect_pc = 32'h3102;
    @(negedge clk);
    redirect_valid = 1'b0;
`ifdef FETCH_ADEL_CHECK_EN
    checks++; if (adel_out !== 1'b1) begin errors++; $display("[TB] FAIL adel_flag got=%0b exp=1", adel_out); end
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("[TB] FAIL adel_valid got=%0b exp=1", instr_valid); end
    checks++; if (pc_out !== 32'h3102) begin errors++; $display("[TB] FAIL adel_pc_out got=%h exp=3102", pc_out); end
    checks++; if (instr_out !== 32'h0) begin errors++; $display("[TB] FAIL adel_instr got=%h exp=0", instr_out); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL adel_req got=%0b exp=0", imem_req); end
    stall_data = 1'b1;
    base = req_count;
    @(negedge clk);
    checks++; if (adel_out !== 1'b1) begin errors++; $display("[TB] FAIL adel_held got=%0b exp=1", adel_out); end
    checks++; if (req_count !== base) begin errors++; $display("[TB] FAIL adel_no_read got=%0d exp=%0d", req_count, base); end
    stall_data = 1'b0;
    @(negedge clk);
    checks++; if (pc_out !== 32'h3106) begin errors++; $display("[TB] FAIL adel_next_pc got=%h exp=3106", pc_out); end
`else
    base = req_count;
    checks++; if (imem_addr !== 32'h3100) begin errors++; $display("[TB] FAIL align_addr got=%h exp=3100", imem_addr); end
    checks++; if (imem_req !== 1'b1) begin errors++; $display("[TB] FAIL align_req got=%0b exp=1", imem_req); end
    checks++; if (adel_out !== 1'b0) begin errors++; $display("[TB] FAIL align_adel got=%0b exp=0", adel_out); end
    repeat (2) @(negedge clk);
    checks++; if (instr_out !== 32'hA500_3100) begin errors++; $display("[TB] FAIL align_instr got=%h exp=a5003100", instr_out); end
    checks++; if (req_count !== base + 1) begin errors++; $display("[TB] FAIL align_reads got=%0d exp=%0d", req_count, base + 1); end
    checks++; if (adel_out !== 1'b0) begin errors++; $display("[TB] FAIL align_adel_late got=%0b exp=0", adel_out); end
`endif
  endtask

  initial begin
    $display("[TB] fetch_stage directed test start");
    test_reset();
    test_first_fetch();
    test_stall();
    test_busy();
    test_redirect_delay_slot();
    test_redirect_hold();
    test_redirect_coincident();
    test_reset_mid_read();
    test_misaligned();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set data/address width.
REQ-002 Parameter RESET_PC, default 32'h0000_3000, SHALL set first fetch address.
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  SHALL be the rising-edge clock.
REQ-005 reset  in  1  SHALL be the asynchronous active-low reset (0 = reset).
REQ-006 stall_data  in  1  SHALL be the downstream data-hazard stall.
REQ-007 busy  in  3  SHALL be the mult/div busy vector; nonzero means stall.
REQ-008 redirect_valid  in  1  SHALL request a control-flow change.
REQ-009 redirect_pc  in  WIDTH  SHALL be the redirect target.
REQ-010 imem_req  out  1  SHALL pulse one cycle to start an instruction read.
REQ-011 imem_addr  out  WIDTH  SHALL be the read address, stable while a read is outstanding.
REQ-012 imem_rvalid  in  1  SHALL pulse one cycle when imem_rdata is valid, at least 1 cycle after imem_req.
REQ-013 imem_rdata  in  WIDTH  SHALL be the returned instruction word.
REQ-014 instr_out  out  WIDTH  SHALL be the fetched instruction; 0 (nop) when instr_valid=0.
REQ-015 pc_out  out  WIDTH  SHALL be the address of instr_out.
REQ-016 instr_valid  out  1  SHALL mark instr_out/pc_out as consumable.
REQ-017 adel_out  out  1  SHALL flag a misaligned fetch (see Configuration).

Function
REQ-018 hold SHALL equal stall_data OR (busy != 0); an instruction is consumed at a rising edge with instr_valid=1 and hold=0.
REQ-019 States SHALL be IDLE, WAIT, VALID; at most one memory read outstanding.
REQ-020 IDLE SHALL assert imem_req at imem_addr=pc and move to WAIT next edge.
REQ-021 WAIT on imem_rvalid SHALL register imem_rdata/pc into instr_out/pc_out, set instr_valid, move to VALID.
REQ-022 VALID while hold=1 SHALL keep all outputs unchanged and issue no request.
REQ-023 VALID on consumption SHALL set pc to next_pc, clear instr_valid, pulse imem_req for next_pc, move to WAIT.
REQ-024 next_pc SHALL be pending target if set (target then cleared), else pc+4 modulo 2^WIDTH.
REQ-025 Redirect SHALL be sampled only at edges with hold=0; with hold=1 it SHALL be ignored.
REQ-026 Redirect SHALL preserve the delay slot: the instruction valid or in flight at redirect is still delivered; redirect_pc is stored as pending target.
REQ-027 A redirect coincident with consumption SHALL be used as next_pc immediately; a second redirect before use SHALL overwrite the pending target.
REQ-028 imem_rvalid outside WAIT SHALL be ignored.
REQ-029 Fetch throughput SHALL be one instruction per (memory latency + 1) cycles minimum.

Reset
REQ-030 Reset assertion SHALL immediately force pc=RESET_PC, state IDLE, instr_out=0, pc_out=RESET_PC, instr_valid=0, imem_req=0, adel_out=0, pending target cleared.
REQ-031 Reset mid-read SHALL abandon the read; its later rvalid SHALL be ignored.
REQ-032 First imem_req SHALL assert in the first cycle after reset deassertion.

Configuration
REQ-033 With FETCH_ADEL_CHECK_EN defined, a next_pc with [1:0]!=0 SHALL issue no read and go directly to VALID with instr_out=0, pc_out=bad pc, adel_out=1, held until consumed.
REQ-034 Without FETCH_ADEL_CHECK_EN, adel_out SHALL be constant 0 and imem_addr[1:0] forced to 0.

Structure
REQ-035 Package pipe_pkg SHALL hold the state enum, RESET_PC default, NOP constant (0) and PC increment (4).
REQ-036 Next-PC selection SHALL be a sub-module fetch_pc_gen; remaining logic in fetch_stage.

Verification
REQ-037 Reset release, 1-cycle memory returning 0x2402_0001 -> imem_addr 0x3000, instr_out 0x2402_0001, pc_out 0x3000, instr_valid 1 after 2 cycles.
REQ-038 stall_data=1 for 5 cycles in VALID -> outputs frozen, no imem_req; release -> next read at 0x3004.
REQ-039 busy=3'b010 while WAIT, response arrives -> captured, held until busy=0, then consumed.
REQ-040 redirect_pc 0x3100 while WAIT for 0x3004 -> 0x3004 delivered (delay slot), next read 0x3100.
REQ-041 reset low during WAIT, rvalid 2 cycles later -> ignored, refetch from 0x3000.
REQ-042 FETCH_ADEL_CHECK_EN, redirect to 0x3102 -> no read, adel_out 1, pc_out 0x3102, instr_out 0.
